// File: rtl/pulse_train_ctrl.sv
// pulse_train_ctrl: programmable pulse-train sequencer.
// Emits cfg_high cycles high and (cfg_period - cfg_high) cycles low per pulse.
// It emits cfg_count pulses, or runs until aborted when cfg_count is 0.
// All outputs come straight from flops.
//
// Handshake: start is a level sampled only while idle. A start in the idle
// cycle is either accepted, giving pulse_out/busy high on the next cycle, or
// rejected, giving a one-cycle cfg_err strobe on the next cycle. start is not
// sampled while busy. abort is sampled every cycle, overrides a coincident
// start, and does nothing while idle.
module pulse_train_ctrl #(
   parameter int CNT_W = 16,
   parameter int NUM_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] cfg_period,
   input  logic [CNT_W-1:0] cfg_high,
   input  logic [NUM_W-1:0] cfg_count,
   output logic             pulse_out,
   output logic             busy,
   output logic             done,
   output logic             cfg_err,
   output logic [NUM_W-1:0] pulses_sent,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HIGH = 2'd1,
      S_LOW  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] phase_q, phase_d;     // cycles spent in current phase, 1-based
   logic [CNT_W-1:0] high_len_q, high_len_d;
   logic [CNT_W-1:0] low_len_q, low_len_d;
   logic [NUM_W-1:0] count_q, count_d;
   logic [NUM_W-1:0] pulses_q, pulses_d;
   logic             pulse_q, pulse_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             cfg_legal;

   // Config is legal when the period holds at least one high and one low cycle.
   always_comb begin
      cfg_legal = (cfg_period >= CNT_W'(2)) && (cfg_high >= CNT_W'(1)) &&
                  (cfg_high < cfg_period);
   end

   // Next-state and next-output logic for the IDLE/HIGH/LOW sequencer.
   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      high_len_d = high_len_q;
      low_len_d  = low_len_q;
      count_d    = count_q;
      pulses_d   = pulses_q;
      pulse_d    = pulse_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               if (cfg_legal) begin
                  // Latch the config so later cfg_* changes cannot disturb the train.
                  high_len_d = cfg_high;
                  low_len_d  = cfg_period - cfg_high;
                  count_d    = cfg_count;
                  pulses_d   = NUM_W'(1);
                  phase_d    = CNT_W'(1);
                  pulse_d    = 1'b1;
                  busy_d     = 1'b1;
                  state_d    = S_HIGH;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         S_HIGH: begin
            if (abort) begin
               state_d = S_IDLE;
               pulse_d = 1'b0;
               busy_d  = 1'b0;
               phase_d = '0;
            end else if (phase_q == high_len_q) begin
               state_d = S_LOW;
               pulse_d = 1'b0;
               phase_d = CNT_W'(1);
            end else begin
               phase_d = phase_q + CNT_W'(1);
            end
         end

         S_LOW: begin
            if (abort) begin
               state_d = S_IDLE;
               pulse_d = 1'b0;
               busy_d  = 1'b0;
               phase_d = '0;
            end else if (phase_q == low_len_q) begin
               if ((count_q != '0) && (pulses_q == count_q)) begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  phase_d = '0;
               end else begin
                  state_d = S_HIGH;
                  pulse_d = 1'b1;
                  phase_d = CNT_W'(1);
                  // Saturate so a long continuous run never wraps the counter.
                  if (pulses_q != '1) begin
                     pulses_d = pulses_q + NUM_W'(1);
                  end
               end
            end else begin
               phase_d = phase_q + CNT_W'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
            pulse_d = 1'b0;
            busy_d  = 1'b0;
            phase_d = '0;
         end
      endcase
   end

   // State and output registers; reset wins over everything, including mid-train.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         phase_q    <= '0;
         high_len_q <= '0;
         low_len_q  <= '0;
         count_q    <= '0;
         pulses_q   <= '0;
         pulse_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         high_len_q <= high_len_d;
         low_len_q  <= low_len_d;
         count_q    <= count_d;
         pulses_q   <= pulses_d;
         pulse_q    <= pulse_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign pulse_out   = pulse_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign cfg_err     = err_q;
   assign pulses_sent = pulses_q;
   assign dbg_state   = state_q;

endmodule
